wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and integer register file for the 64-bit five-stage pipeline. It consumes the MEM/WB pipeline register outputs (control bits, load data, ALU result, destination register) and selects the write-back value. It commits that value into a 32 x 64-bit register file and serves the two decode-stage read ports, with same-cycle write-to-read bypass. It also keeps a committed-write counter and a registered record of the last commit for debug and verification.

## Interface

Parameters:
- `XLEN`, 64, data width of registers and write-back path.
- `NREG`, 32, number of architectural registers; index width is 5.

Ports:
- `clk`  input  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  input  1  reset. One clock; reset is synchronous and active-low.
- `Mem_to_Reg`  input  1  write-back source select: 1 selects load data, 0 selects ALU result.
- `Reg_Write`  input  1  commit enable for this cycle's write-back.
- `Read_Data`  input  XLEN  load data from the MEM/WB register.
- `Mem_Address`  input  XLEN  ALU result / address from the MEM/WB register.
- `rd`  input  5  destination register index.
- `rs1`  input  5  decode read port 1 index.
- `rs2`  input  5  decode read port 2 index.
- `rs1_data`  output  XLEN  read port 1 data (combinational).
- `rs2_data`  output  XLEN  read port 2 data (combinational).
- `wb_data`  output  XLEN  combinational write-back value this cycle, used as the forwarding source for EX.
- `wb_commit_q`  output  1  registered; 1 if a commit occurred at the last edge.
- `wb_rd_q`  output  5  registered index of the last commit.
- `wb_data_q`  output  XLEN  registered value of the last commit.
- `wb_count`  output  32  number of committed writes since reset.

## Operation

- Write-back value: `wb_data = Mem_to_Reg ? Read_Data : Mem_Address`. It is purely combinational and is driven regardless of `Reg_Write`.
- Commit condition: `commit = rst_n & Reg_Write & (rd != 0)`.
- On a clock edge with `commit`, register `rd` takes the value of `wb_data`.
- Register x0 always reads 0. Writes to x0 are discarded and are not counted.
- Read ports:
  - If `rsN == 0`, the port returns 0.
  - Else, if `commit` and `rsN == rd` in the same cycle, the port returns `wb_data` (write-through bypass).
  - Otherwise the port returns the stored register.
- Both ports are independent. When `rs1 == rs2`, both ports return the same value, including the bypass case.
- Debug record: each edge loads `wb_commit_q <= commit`. When `commit`, the same edge loads `wb_rd_q <= rd` and `wb_data_q <= wb_data`. Otherwise `wb_rd_q` and `wb_data_q` hold their values.
- Counter: `wb_count` increments by 1 on each edge with `commit` and wraps modulo 2^32 (0xFFFFFFFF rolls to 0). It never saturates.
- Reset (edge with `rst_n = 0`):
  - All registers x1 to x31 are cleared to 0.
  - `wb_commit_q = 0`, `wb_rd_q = 0`, `wb_data_q = 0`, `wb_count = 0`.
  - Any `Reg_Write` in the same cycle is ignored; no write and no count.
  - Read ports are gated by `commit`, so during reset they show no bypass.
- Reset mid-stream: a pending write-back in the reset cycle is lost. The first commit after `rst_n` rises takes effect at the first edge with `rst_n = 1`.
- Unknown or X `Reg_Write` is not handled. The verification bench must drive it to a known value.

## Timing

- Write latency is 1 edge. A value presented in cycle N is readable from storage in cycle N+1, and is visible in cycle N through the bypass.
- Read latency is 0. `rs1_data` and `rs2_data` are combinational from `rs1`/`rs2`, storage, and the current write-back inputs.
- `wb_data` is combinational from `Mem_to_Reg`, `Read_Data` and `Mem_Address`. It carries no state.
- `wb_commit_q`, `wb_rd_q`, `wb_data_q` and `wb_count` update at the same edge as the storage write.
- There are no stalls and no handshake. A write-back is accepted every cycle.
- Reset values of every output:
  - `rs1_data` = `rs2_data` = 0, because storage is cleared and there is no commit.
  - `wb_data` follows its inputs.
  - `wb_commit_q` = 0, `wb_rd_q` = 0, `wb_data_q` = 0, `wb_count` = 0.

## Test plan

1. **Reset clear:** write x5 = 0xDEAD, then one reset cycle, then read rs1 = 5 → 0. `wb_count` = 0 and `wb_commit_q` = 0.
2. **Source select and commit:**
   - `Reg_Write = 1`, `rd = 3`, `Mem_to_Reg = 0`, `Mem_Address = 0x1234`, `Read_Data = 0xFFFF` → next cycle x3 = 0x1234.
   - Repeat with `Mem_to_Reg = 1` → x3 = 0xFFFF.
   - `wb_count` = 2; `wb_rd_q` = 3; `wb_data_q` = 0xFFFF.
3. **Bypass:** in a single cycle, commit `rd = 7` with value 0xA5A5, `rs1 = 7`, `rs2 = 7` → both ports read 0xA5A5 in that cycle while storage still holds the old value.
4. **x0 protection:** `Reg_Write = 1`, `rd = 0`, value 0x55 → `rs1 = 0` reads 0 in the same cycle and the next cycle. `wb_count` and `wb_commit_q` are unchanged or 0.
5. **Reset with pending write:** `rst_n = 0` together with `Reg_Write = 1`, `rd = 9`, value 0x77 → x9 = 0 after the edge and `wb_count` = 0. The next cycle, with `rst_n = 1`, the same write lands: x9 = 0x77 and `wb_count` = 1.
6. **Counter wrap:** preload `wb_count` to 0xFFFFFFFE by force or a long run, then commit twice → 0xFFFFFFFF, then 0x00000000.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back select, 32 x XLEN integer register file with write-through bypass, and commit debug record.
// Latency: reads and wb_data are combinational; storage, debug record and counter update 1 edge after commit.
// No backpressure: one write-back is accepted every cycle; reset is synchronous, active-low.
module wb_regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Mem_to_Reg,
    input  logic            Reg_Write,
    input  logic [XLEN-1:0] Read_Data,
    input  logic [XLEN-1:0] Mem_Address,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_commit_q,
    output logic [4:0]      wb_rd_q,
    output logic [XLEN-1:0] wb_data_q,
    output logic [31:0]     wb_count
);

    logic [XLEN-1:0] r_rf [0:NREG-1];
    logic            r_commit_q;
    logic [4:0]      r_rd_q;
    logic [XLEN-1:0] r_data_q;
    logic [31:0]     r_count;

    logic [XLEN-1:0] w_wb_data;
    logic            w_commit;

    assign w_wb_data = Mem_to_Reg ? Read_Data : Mem_Address;
    // rst_n in the commit term also suppresses the bypass during reset.
    assign w_commit  = rst_n & Reg_Write & (rd != 5'd0);

    function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
        if (idx == 5'd0)
            return '0;
        else if (w_commit && (idx == rd))
            return w_wb_data;
        else
            return r_rf[idx];
    endfunction

    always_comb begin
        rs1_data = read_port(rs1);
        rs2_data = read_port(rs2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                r_rf[i] <= '0;
            r_commit_q <= 1'b0;
            r_rd_q     <= 5'd0;
            r_data_q   <= '0;
            r_count    <= 32'd0;
        end else begin
            r_commit_q <= w_commit;
            if (w_commit) begin
                r_rf[rd] <= w_wb_data;
                r_rd_q   <= rd;
                r_data_q <= w_wb_data;
                r_count  <= r_count + 32'd1;
            end
        end
    end

    assign wb_data     = w_wb_data;
    assign wb_commit_q = r_commit_q;
    assign wb_rd_q     = r_rd_q;
    assign wb_data_q   = r_data_q;
    assign wb_count    = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed test-plan steps, then randomized traffic, all checked against an array model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Mem_to_Reg;
    logic        Reg_Write;
    logic [63:0] Read_Data;
    logic [63:0] Mem_Address;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] rs1_data, rs2_data, wb_data, wb_data_q;
    logic        wb_commit_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_count;

    int n_vec = 0;
    int n_err = 0;

    // Architectural model: plain array plus last-commit record.
    logic [63:0] m_rf [32];
    logic        m_commit_q;
    logic [4:0]  m_rd_q;
    logic [63:0] m_data_q;
    logic [31:0] m_count;

    always #5 clk = ~clk;

    wb_regfile #(.XLEN(64), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n), .Mem_to_Reg(Mem_to_Reg), .Reg_Write(Reg_Write),
        .Read_Data(Read_Data), .Mem_Address(Mem_Address), .rd(rd), .rs1(rs1), .rs2(rs2),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data),
        .wb_commit_q(wb_commit_q), .wb_rd_q(wb_rd_q), .wb_data_q(wb_data_q), .wb_count(wb_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_read(input logic [4:0] s, input logic c,
                                             input logic [4:0] d, input logic [63:0] v);
        if (s == 0) return 64'd0;
        if (c && s == d) return v;
        return m_rf[s];
    endfunction

    task automatic step(input logic rn, input logic we, input logic m2r,
                        input logic [63:0] rdat, input logic [63:0] addr,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        logic [63:0] exp_wb;
        logic        exp_c;
        rst_n = rn; Reg_Write = we; Mem_to_Reg = m2r;
        Read_Data = rdat; Mem_Address = addr; rd = d; rs1 = s1; rs2 = s2;
        #1;
        exp_wb = m2r ? rdat : addr;
        exp_c  = rn && we && (d != 0);
        chk("wb_data",  wb_data,  exp_wb);
        chk("rs1_data", rs1_data, ref_read(s1, exp_c, d, exp_wb));
        chk("rs2_data", rs2_data, ref_read(s2, exp_c, d, exp_wb));
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
            m_commit_q = 0; m_rd_q = 0; m_data_q = 0; m_count = 0;
        end else begin
            m_commit_q = exp_c;
            if (exp_c) begin
                m_rf[d] = exp_wb; m_rd_q = d; m_data_q = exp_wb; m_count = m_count + 1;
            end
        end
        #1;
        chk("wb_commit_q", {63'd0, wb_commit_q}, {63'd0, m_commit_q});
        chk("wb_rd_q",     {59'd0, wb_rd_q},     {59'd0, m_rd_q});
        chk("wb_data_q",   wb_data_q,            m_data_q);
        chk("wb_count",    {32'd0, wb_count},    {32'd0, m_count});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
        m_commit_q = 0; m_rd_q = 0; m_data_q = 0; m_count = 0;

        // Initial reset; reads of x0 only since storage is still unknown.
        step(0, 0, 0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0);
        step(0, 1, 0, 64'd0, 64'h11, 5'd4, 5'd0, 5'd0);

        // Reset clear
        step(1, 1, 0, 64'd0, 64'hDEAD, 5'd5, 5'd5, 5'd0);
        step(0, 0, 0, 64'd0, 64'd0, 5'd0, 5'd5, 5'd5);
        step(1, 0, 0, 64'd0, 64'd0, 5'd0, 5'd5, 5'd0);
        chk("reset_clear_x5", rs1_data, 64'd0);
        chk("reset_count", {32'd0, wb_count}, 64'd0);

        // Source select and commit
        step(1, 1, 0, 64'hFFFF, 64'h1234, 5'd3, 5'd0, 5'd0);
        step(1, 1, 1, 64'hFFFF, 64'h1234, 5'd3, 5'd3, 5'd0);
        chk("count_after_two", {32'd0, wb_count}, 64'd2);
        chk("rd_q_3", {59'd0, wb_rd_q}, 64'd3);
        chk("data_q_ffff", wb_data_q, 64'hFFFF);
        step(1, 0, 0, 64'd0, 64'd0, 5'd0, 5'd3, 5'd3);

        // Bypass on both ports, then storage holds the new value
        step(1, 1, 0, 64'd0, 64'h5A5A, 5'd7, 5'd0, 5'd0);
        step(1, 1, 0, 64'd0, 64'hA5A5, 5'd7, 5'd7, 5'd7);
        step(1, 0, 0, 64'd0, 64'd0, 5'd0, 5'd7, 5'd7);
        chk("x7_stored", rs2_data, 64'hA5A5);

        // x0 protection
        step(1, 1, 0, 64'd0, 64'h55, 5'd0, 5'd0, 5'd0);
        step(1, 0, 0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0);
        chk("x0_commit_q", {63'd0, wb_commit_q}, 64'd0);

        // Reset with pending write, then the same write lands
        step(0, 1, 0, 64'd0, 64'h77, 5'd9, 5'd9, 5'd0);
        step(1, 1, 0, 64'd0, 64'h77, 5'd9, 5'd9, 5'd0);
        step(1, 0, 0, 64'd0, 64'd0, 5'd0, 5'd9, 5'd0);
        chk("x9_after_reset", rs1_data, 64'h77);
        chk("count_after_reset", {32'd0, wb_count}, 64'd1);

        // Counter wrap via preload
        force dut.r_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_count;
        m_count = 32'hFFFF_FFFE;
        #1;
        chk("count_preload", {32'd0, wb_count}, 64'hFFFF_FFFE);
        step(1, 1, 0, 64'd0, 64'h1, 5'd1, 5'd0, 5'd0);
        chk("count_ffffffff", {32'd0, wb_count}, 64'hFFFF_FFFF);
        step(1, 1, 0, 64'd0, 64'h2, 5'd2, 5'd1, 5'd0);
        chk("count_wrap", {32'd0, wb_count}, 64'd0);

        // Randomized traffic with occasional reset and biased bypass hits
        for (int n = 0; n < 400; n++) begin
            logic [4:0] d, s1, s2;
            d  = 5'($urandom_range(0, 31));
            s1 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
            s2 = ($urandom_range(0, 3) == 0) ? s1 : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 49) != 0), 1'($urandom), 1'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom}, d, s1, s2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
